// File: rtl/count8dnfsm.sv
// rtl/count8dnfsm.sv - loadable 8-bit down-counter/timer FSM with terminal count and auto-reload
//
// Purpose:
//   Loads an 8-bit interval and counts it down to zero while En is high.
//   On the terminal edge (cnt==1 with En high) a one-cycle tc pulse is
//   raised. The counter then either parks in DONE with cnt=0, or reloads
//   the captured interval and keeps running when AutoRl is high, which
//   turns the block into a periodic tick generator.
//
// Ports:
//   Clk     in   1  rising-edge clock, sole clock domain
//   Res     in   1  synchronous active-high reset
//   En      in   1  count enable
//   Load    in   1  load strobe, captures cnt_in in any state
//   AutoRl  in   1  auto-reload select, sampled on the terminal edge only
//   Ack     in   1  returns DONE to IDLE
//   cnt_in  in   8  value to load
//   cnt     out  8  current count (registered)
//   tc      out  1  terminal-count pulse (registered, one cycle)
//   busy    out  1  state == RUN
//   done    out  1  state == DONE
//
// Edge priority: Res > Load > Ack > En.

module count8dnfsm (
    input  logic       Clk,
    input  logic       Res,
    input  logic       En,
    input  logic       Load,
    input  logic       AutoRl,
    input  logic       Ack,
    input  logic [7:0] cnt_in,
    output logic [7:0] cnt,
    output logic       tc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt_q, cnt_nxt;
    logic [7:0] rld_q, rld_nxt;
    logic       tc_q,  tc_nxt;

    // Terminal edge: the enabled decrement that would reach zero.
    logic       term_edge;
    assign term_edge = (state == RUN) && En && (cnt_q == 8'd1);

    // State and datapath registers. Reset overrides every other input,
    // which also drops any tc that the same edge would have produced.
    always_ff @(posedge Clk) begin
        if (Res) begin
            state <= IDLE;
            cnt_q <= 8'd0;
            rld_q <= 8'd0;
            tc_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            rld_q <= rld_nxt;
            tc_q  <= tc_nxt;
        end
    end

    // Next-state and next-datapath logic. tc defaults low so that it is a
    // single-cycle pulse unless another terminal edge follows directly.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        rld_nxt   = rld_q;
        tc_nxt    = 1'b0;

        if (Load) begin
            // Load beats Ack and En, including on a terminal edge, so a
            // load there never reports tc. A zero interval has nothing to
            // count and stays idle.
            cnt_nxt   = cnt_in;
            rld_nxt   = cnt_in;
            state_nxt = (cnt_in != 8'd0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // Holds count; En and Ack have no effect here.
                end

                RUN: begin
                    if (term_edge) begin
                        tc_nxt = 1'b1;
                        if (AutoRl) begin
                            cnt_nxt = rld_q;
                        end else begin
                            cnt_nxt   = 8'd0;
                            state_nxt = DONE;
                        end
                    end else if (En && (cnt_q > 8'd1)) begin
                        cnt_nxt = cnt_q - 8'd1;
                    end else if (cnt_q == 8'd0) begin
                        // RUN is only entered with a non-zero count and
                        // reload value; fall back to IDLE rather than
                        // ever decrementing from zero.
                        state_nxt = IDLE;
                    end
                end

                DONE: begin
                    // Parked at zero; enable must not wrap to 8'hFF.
                    cnt_nxt = 8'd0;
                    if (Ack) begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Outputs are taken straight from registers.
    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_count8dnfsm.sv
// tb/tb_count8dnfsm.sv - directed self-checking bench for count8dnfsm

module tb_count8dnfsm;

    logic       Clk;
    logic       Res;
    logic       En;
    logic       Load;
    logic       AutoRl;
    logic       Ack;
    logic [7:0] cnt_in;
    logic [7:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    count8dnfsm dut (
        .Clk    (Clk),
        .Res    (Res),
        .En     (En),
        .Load   (Load),
        .AutoRl (AutoRl),
        .Ack    (Ack),
        .cnt_in (cnt_in),
        .cnt    (cnt),
        .tc     (tc),
        .busy   (busy),
        .done   (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full output set in one go.
    task automatic chk_all(input string tag, input logic [7:0] e_cnt, input logic e_tc,
                           input logic e_busy, input logic e_done);
        chk({tag, ".cnt"},  {24'd0, cnt},  {24'd0, e_cnt});
        chk({tag, ".tc"},   {31'd0, tc},   {31'd0, e_tc});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    initial begin
        int early_tc;

        // Reset held two cycles while other inputs are active.
        Res = 1'b1; Load = 1'b1; cnt_in = 8'h55; En = 1'b1; AutoRl = 1'b0; Ack = 1'b0;
        step();
        step();
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        Res = 1'b0; Load = 1'b0; En = 1'b0;
        step();
        chk_all("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot count of 3.
        Load = 1'b1; cnt_in = 8'd3; En = 1'b1; AutoRl = 1'b0;
        step();
        chk_all("os_load", 8'd3, 1'b0, 1'b1, 1'b0);
        Load = 1'b0;
        step();
        chk_all("os_2", 8'd2, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("os_1", 8'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("os_expire", 8'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("os_done_hold", 8'd0, 1'b0, 1'b0, 1'b1);
        Ack = 1'b1;
        step();
        chk_all("os_ack", 8'd0, 1'b0, 1'b0, 1'b0);
        Ack = 1'b0;

        // Auto-reload with period 2.
        Load = 1'b1; cnt_in = 8'd2; AutoRl = 1'b1; En = 1'b1;
        step();
        chk_all("ar_load", 8'd2, 1'b0, 1'b1, 1'b0);
        Load = 1'b0;
        step();
        chk_all("ar_1a", 8'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("ar_rl_a", 8'd2, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("ar_1b", 8'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("ar_rl_b", 8'd2, 1'b1, 1'b1, 1'b0);

        // Auto-reload with period 1: tc every cycle.
        Load = 1'b1; cnt_in = 8'd1;
        step();
        chk_all("ar1_load", 8'd1, 1'b0, 1'b1, 1'b0);
        Load = 1'b0;
        step();
        chk_all("ar1_tick_a", 8'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("ar1_tick_b", 8'd1, 1'b1, 1'b1, 1'b0);

        // Enable gating: 5 then En 1,0,0,1,1.
        AutoRl = 1'b0; Load = 1'b1; cnt_in = 8'd5; En = 1'b0;
        step();
        chk_all("en_load", 8'd5, 1'b0, 1'b1, 1'b0);
        Load = 1'b0; En = 1'b1;
        step();
        chk_all("en_4", 8'd4, 1'b0, 1'b1, 1'b0);
        En = 1'b0;
        step();
        chk_all("en_hold_a", 8'd4, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("en_hold_b", 8'd4, 1'b0, 1'b1, 1'b0);
        En = 1'b1;
        step();
        chk_all("en_3", 8'd3, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("en_2", 8'd2, 1'b0, 1'b1, 1'b0);

        // Ack while running is ignored.
        Ack = 1'b1; En = 1'b0;
        step();
        chk_all("ack_in_run", 8'd2, 1'b0, 1'b1, 1'b0);
        Ack = 1'b0;

        // Loading zero goes idle without tc.
        Load = 1'b1; cnt_in = 8'd0; En = 1'b1;
        step();
        chk_all("load_zero", 8'd0, 1'b0, 1'b0, 1'b0);
        Load = 1'b0;
        step();
        chk_all("load_zero_hold", 8'd0, 1'b0, 1'b0, 1'b0);

        // Full-scale interval: tc after exactly 255 cycles.
        Load = 1'b1; cnt_in = 8'hFF; En = 1'b1;
        step();
        chk_all("ff_load", 8'hFF, 1'b0, 1'b1, 1'b0);
        Load = 1'b0;
        early_tc = 0;
        for (int i = 1; i < 255; i++) begin
            step();
            if (tc !== 1'b0) early_tc++;
        end
        chk("ff_no_early_tc", early_tc, 0);
        chk_all("ff_pre_expire", 8'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("ff_expire", 8'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("ff_no_wrap", 8'd0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a run.
        Load = 1'b1; cnt_in = 8'd9;
        step();
        Load = 1'b0;
        step();
        step();
        chk_all("mid_run_7", 8'd7, 1'b0, 1'b1, 1'b0);
        Res = 1'b1;
        step();
        chk_all("mid_run_reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset and load on the same edge: reset wins.
        Load = 1'b1; cnt_in = 8'd9;
        step();
        chk_all("res_load", 8'd0, 1'b0, 1'b0, 1'b0);
        Res = 1'b0; Load = 1'b0;

        // Reset on a terminal edge suppresses the pending tc.
        Load = 1'b1; cnt_in = 8'd1; En = 1'b1;
        step();
        chk_all("res_tc_load", 8'd1, 1'b0, 1'b1, 1'b0);
        Load = 1'b0; Res = 1'b1;
        step();
        chk_all("res_tc_suppress", 8'd0, 1'b0, 1'b0, 1'b0);
        Res = 1'b0;

        // Load on a terminal edge: load wins, no tc.
        Load = 1'b1; cnt_in = 8'd2;
        step();
        Load = 1'b0;
        step();
        chk_all("lt_pre", 8'd1, 1'b0, 1'b1, 1'b0);
        Load = 1'b1; cnt_in = 8'd9;
        step();
        chk_all("lt_load_wins", 8'd9, 1'b0, 1'b1, 1'b0);
        Load = 1'b0; En = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
